// File: rtl/sram_arbiter_if.sv
// rtl/sram_arbiter_if.sv - two-master request ports plus the shared SRAM slave port
interface sram_arbiter_if;
  logic        m0_req;
  logic [31:0] m0_addr;
  logic [5:0]  m0_we;
  logic [47:0] m0_din;
  logic [47:0] m0_dout;
  logic        m0_ack;
  logic        m0_err;

  logic        m1_req;
  logic [31:0] m1_addr;
  logic [5:0]  m1_we;
  logic [47:0] m1_din;
  logic [47:0] m1_dout;
  logic        m1_ack;
  logic        m1_err;

  logic        s_stb;
  logic [31:0] s_addr;
  logic [5:0]  s_we;
  logic [47:0] s_din;
  logic [47:0] s_dout;
  logic        s_nak;
  logic        busy;

  // Arbiter side
  modport slave (
    input  m0_req, m0_addr, m0_we, m0_din,
    output m0_dout, m0_ack, m0_err,
    input  m1_req, m1_addr, m1_we, m1_din,
    output m1_dout, m1_ack, m1_err,
    output s_stb, s_addr, s_we, s_din,
    input  s_dout, s_nak,
    output busy
  );

  // Environment side: requesting masters and the SRAM controller
  modport master (
    output m0_req, m0_addr, m0_we, m0_din,
    input  m0_dout, m0_ack, m0_err,
    output m1_req, m1_addr, m1_we, m1_din,
    input  m1_dout, m1_ack, m1_err,
    input  s_stb, s_addr, s_we, s_din,
    output s_dout, s_nak,
    input  busy
  );
endinterface

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-master arbiter with watchdog in front of the SRAM controller port
module sram_arbiter #(
  parameter bit          RR      = 1'b1,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  sram_arbiter_if.slave bus
);

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, BUSY, DONE} state_e;

  state_e      state_q;
  logic        gnt_q;
  logic        last_q;
  logic [7:0]  wdog_q;
  logic        s_stb_q;
  logic [31:0] s_addr_q;
  logic [5:0]  s_we_q;
  logic [47:0] s_din_q;
  logic [47:0] m0_dout_q;
  logic [47:0] m1_dout_q;
  logic        m0_ack_q;
  logic        m1_ack_q;
  logic        m0_err_q;
  logic        m1_err_q;
  logic        busy_q;

  logic        any_req;
  logic        win;
  logic [31:0] win_addr;
  logic [5:0]  win_we;
  logic [47:0] win_din;
  logic        wdog_hit;

  always_comb begin
    any_req = bus.m0_req | bus.m1_req;
    if (RR) begin
      // Both requesting: the master that did not win last time
      win = (bus.m0_req && bus.m1_req) ? ~last_q : bus.m1_req;
    end else begin
      win = ~bus.m0_req;
    end
    win_addr = win ? bus.m1_addr : bus.m0_addr;
    win_we   = win ? bus.m1_we   : bus.m0_we;
    win_din  = win ? bus.m1_din  : bus.m0_din;
    wdog_hit = (wdog_q == TMO);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      wdog_q    <= 8'd0;
      s_stb_q   <= 1'b0;
      s_addr_q  <= 32'd0;
      s_we_q    <= 6'd0;
      s_din_q   <= 48'd0;
      m0_dout_q <= 48'd0;
      m1_dout_q <= 48'd0;
      m0_ack_q  <= 1'b0;
      m1_ack_q  <= 1'b0;
      m0_err_q  <= 1'b0;
      m1_err_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      m0_ack_q <= 1'b0;
      m1_ack_q <= 1'b0;
      m0_err_q <= 1'b0;
      m1_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_req) begin
            gnt_q    <= win;
            last_q   <= win;
            s_addr_q <= win_addr;
            s_we_q   <= win_we;
            s_din_q  <= win_din;
            s_stb_q  <= 1'b1;
            wdog_q   <= 8'd0;
            busy_q   <= 1'b1;
            state_q  <= REQ;
          end
        end
        REQ: begin
          if (wdog_hit) begin
            s_stb_q <= 1'b0;
            if (gnt_q) begin m1_ack_q <= 1'b1; m1_err_q <= 1'b1; end
            else       begin m0_ack_q <= 1'b1; m0_err_q <= 1'b1; end
            state_q <= DONE;
          end else if (bus.s_nak) begin
            s_stb_q <= 1'b0;
            wdog_q  <= 8'd0;
            state_q <= BUSY;
          end else begin
            wdog_q <= wdog_q + 8'd1;
          end
        end
        BUSY: begin
          if (wdog_hit) begin
            if (gnt_q) begin m1_ack_q <= 1'b1; m1_err_q <= 1'b1; end
            else       begin m0_ack_q <= 1'b1; m0_err_q <= 1'b1; end
            state_q <= DONE;
          end else if (!bus.s_nak) begin
            // Writes leave the master's read data untouched
            if (s_we_q == 6'd0) begin
              if (gnt_q) m1_dout_q <= bus.s_dout;
              else       m0_dout_q <= bus.s_dout;
            end
            if (gnt_q) m1_ack_q <= 1'b1;
            else       m0_ack_q <= 1'b1;
            state_q <= DONE;
          end else begin
            wdog_q <= wdog_q + 8'd1;
          end
        end
        DONE: begin
          s_addr_q <= 32'd0;
          s_we_q   <= 6'd0;
          s_din_q  <= 48'd0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.m0_dout = m0_dout_q;
  assign bus.m0_ack  = m0_ack_q;
  assign bus.m0_err  = m0_err_q;
  assign bus.m1_dout = m1_dout_q;
  assign bus.m1_ack  = m1_ack_q;
  assign bus.m1_err  = m1_err_q;
  assign bus.s_stb   = s_stb_q;
  assign bus.s_addr  = s_addr_q;
  assign bus.s_we    = s_we_q;
  assign bus.s_din   = s_din_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - scoreboard bench: DUT0 round-robin, DUT1 fixed priority, both TIMEOUT=16
module tb_sram_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic        m_req  [2][2];
  logic [31:0] m_addr [2][2];
  logic [5:0]  m_we   [2][2];
  logic [47:0] m_din  [2][2];
  logic [47:0] m_dout [2][2];
  logic        m_ack  [2][2];
  logic        m_err  [2][2];
  logic        s_stb  [2];
  logic [31:0] s_addr [2];
  logic [5:0]  s_we   [2];
  logic [47:0] s_din  [2];
  logic [47:0] s_dout [2];
  logic        s_nak  [2];
  logic        busy   [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sram_arbiter_if bus();
    sram_arbiter #(.RR(g == 0), .TIMEOUT(16)) dut (.clk(clk), .rst(rst), .bus(bus));
    assign bus.m0_req  = m_req[g][0];
    assign bus.m0_addr = m_addr[g][0];
    assign bus.m0_we   = m_we[g][0];
    assign bus.m0_din  = m_din[g][0];
    assign bus.m1_req  = m_req[g][1];
    assign bus.m1_addr = m_addr[g][1];
    assign bus.m1_we   = m_we[g][1];
    assign bus.m1_din  = m_din[g][1];
    assign bus.s_dout  = s_dout[g];
    assign bus.s_nak   = s_nak[g];
    assign m_dout[g][0] = bus.m0_dout;
    assign m_ack[g][0]  = bus.m0_ack;
    assign m_err[g][0]  = bus.m0_err;
    assign m_dout[g][1] = bus.m1_dout;
    assign m_ack[g][1]  = bus.m1_ack;
    assign m_err[g][1]  = bus.m1_err;
    assign s_stb[g]  = bus.s_stb;
    assign s_addr[g] = bus.s_addr;
    assign s_we[g]   = bus.s_we;
    assign s_din[g]  = bus.s_din;
    assign busy[g]   = bus.busy;
  end

  function automatic logic [47:0] rdata(input logic [31:0] a);
    return (a == 32'h10) ? 48'h1234_5678_9ABC : {16'hC0DE, a};
  endfunction

  // SRAM controller model: nak high for 5 cycles, result valid as nak falls
  logic        stuck [2];
  int          cnt   [2];
  logic [31:0] lat_addr [2];
  logic [5:0]  lat_we   [2];

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        s_nak[d]  <= 1'b0;
        s_dout[d] <= 48'd0;
        cnt[d]    <= 0;
      end else if (stuck[d]) begin
        s_nak[d]  <= 1'b0;
        s_dout[d] <= 48'hBAD0_BAD0_BAD0;
      end else if (cnt[d] != 0) begin
        cnt[d] <= cnt[d] - 1;
        if (cnt[d] == 1) begin
          s_nak[d]  <= 1'b0;
          s_dout[d] <= (lat_we[d] == 6'd0) ? rdata(lat_addr[d]) : 48'hDEAD_DEAD_DEAD;
        end
      end else if (s_stb[d]) begin
        s_nak[d]    <= 1'b1;
        cnt[d]      <= 5;
        lat_addr[d] <= s_addr[d];
        lat_we[d]   <= s_we[d];
      end
    end
  end

  typedef struct {
    int          d;
    int          m;
    logic [47:0] dout;
    logic        err;
    int          c;
  } exp_t;

  exp_t        sb[$];
  logic [47:0] exp_dout [2][2];

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  task automatic expect_ack(input int d, input int m, input logic err, input int c);
    exp_t e;
    e.d = d; e.m = m; e.dout = exp_dout[d][m]; e.err = err; e.c = c;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      for (int m = 0; m < 2; m++) begin
        if (m_err[d][m] === 1'b1 && m_ack[d][m] !== 1'b1) begin
          total++; bad++;
          $display("FAIL err_without_ack dut%0d m%0d cyc %0d", d, m, cyc);
        end
        if (m_ack[d][m] === 1'b1) begin
          if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_ack dut%0d m%0d cyc %0d: got ack want none", d, m, cyc);
          end else begin
            e = sb.pop_front();
            check("ack_source", 192'(d * 2 + m), 192'(e.d * 2 + e.m));
            check("ack_cycle", 192'(cyc), 192'(e.c));
            check("ack_dout", 192'(m_dout[d][m]), 192'(e.dout));
            check("ack_err", 192'(m_err[d][m]), 192'(e.err));
          end
        end
      end
    end
  end

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at_neg(input int c);
    goto(c);
    @(negedge clk);
  endtask

  function automatic logic [191:0] all_out(input int d);
    return 192'({m_dout[d][0], m_ack[d][0], m_err[d][0], m_dout[d][1], m_ack[d][1], m_err[d][1],
                 s_stb[d], s_addr[d], s_we[d], s_din[d], busy[d]});
  endfunction

  initial begin
    int t;
    for (int d = 0; d < 2; d++) begin
      stuck[d] = 1'b0;
      for (int m = 0; m < 2; m++) begin
        m_req[d][m] = 1'b0; m_addr[d][m] = '0; m_we[d][m] = '0; m_din[d][m] = '0;
        exp_dout[d][m] = '0;
      end
    end
    goto(3);
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs_dut0", all_out(0), '0);
    check("reset_outputs_dut1", all_out(1), '0);

    // m0 read at 0x10
    goto(cyc + 2);
    t = cyc;
    m_req[0][0] = 1'b1; m_addr[0][0] = 32'h10; m_we[0][0] = 6'd0;
    exp_dout[0][0] = 48'h1234_5678_9ABC;
    expect_ack(0, 0, 1'b0, t + 8);
    at_neg(t + 1);
    check("rd_stb_t1", 192'(s_stb[0]), 192'(1'b1));
    check("rd_addr_t1", 192'(s_addr[0]), 192'(32'h10));
    check("rd_busy_t1", 192'(busy[0]), 192'(1'b1));
    at_neg(t + 3);
    check("rd_stb_t3", 192'(s_stb[0]), 192'(1'b0));
    goto(t + 9);
    m_req[0][0] = 1'b0;
    @(negedge clk);
    check("rd_busy_t9", 192'(busy[0]), 192'(1'b0));
    check("rd_addr_cleared", 192'(s_addr[0]), 192'(0));

    // m1 partial write at 0x40
    goto(cyc + 2);
    t = cyc;
    m_req[0][1] = 1'b1; m_addr[0][1] = 32'h40; m_we[0][1] = 6'b000011; m_din[0][1] = 48'hAAAA_BBBB_CCCC;
    expect_ack(0, 1, 1'b0, t + 8);
    at_neg(t + 1);
    check("wr_stb", 192'(s_stb[0]), 192'(1'b1));
    check("wr_addr", 192'(s_addr[0]), 192'(32'h40));
    check("wr_we", 192'(s_we[0]), 192'(6'b000011));
    check("wr_din", 192'(s_din[0]), 192'(48'hAAAA_BBBB_CCCC));
    goto(t + 9);
    m_req[0][1] = 1'b0; m_we[0][1] = 6'd0;

    // Round-robin, both held for four transactions
    goto(cyc + 2);
    t = cyc;
    m_addr[0][0] = 32'h100; m_addr[0][1] = 32'h200;
    m_req[0][0] = 1'b1; m_req[0][1] = 1'b1;
    exp_dout[0][0] = 48'hC0DE_0000_0100;
    exp_dout[0][1] = 48'hC0DE_0000_0200;
    expect_ack(0, 0, 1'b0, t + 8);
    expect_ack(0, 1, 1'b0, t + 17);
    expect_ack(0, 0, 1'b0, t + 26);
    expect_ack(0, 1, 1'b0, t + 35);
    at_neg(t + 10);
    check("rr_second_grant_addr", 192'(s_addr[0]), 192'(32'h200));
    goto(t + 36);
    m_req[0][0] = 1'b0; m_req[0][1] = 1'b0;

    // Fixed priority on DUT1: m0 wins every time
    goto(cyc + 2);
    t = cyc;
    m_addr[1][0] = 32'h500; m_addr[1][1] = 32'h600;
    m_req[1][0] = 1'b1; m_req[1][1] = 1'b1;
    exp_dout[1][0] = 48'hC0DE_0000_0500;
    expect_ack(1, 0, 1'b0, t + 8);
    expect_ack(1, 0, 1'b0, t + 17);
    expect_ack(1, 0, 1'b0, t + 26);
    goto(t + 27);
    m_req[1][0] = 1'b0; m_req[1][1] = 1'b0;
    @(negedge clk);
    check("fp_idle_after", 192'(busy[1]), 192'(1'b0));

    // Watchdog: slave never answers
    goto(cyc + 2);
    stuck[0] = 1'b1;
    goto(cyc + 1);
    t = cyc;
    m_addr[0][0] = 32'h300; m_req[0][0] = 1'b1;
    expect_ack(0, 0, 1'b1, t + 18);
    at_neg(t + 17);
    check("to_stb_t17", 192'(s_stb[0]), 192'(1'b1));
    at_neg(t + 18);
    check("to_stb_t18", 192'(s_stb[0]), 192'(1'b0));
    goto(t + 19);
    m_req[0][0] = 1'b0;
    @(negedge clk);
    check("to_busy_t19", 192'(busy[0]), 192'(1'b0));
    stuck[0] = 1'b0;

    // Reset in the middle of a read, then a fresh read
    goto(cyc + 2);
    t = cyc;
    m_addr[0][0] = 32'h10; m_req[0][0] = 1'b1;
    goto(t + 4);
    rst = 1'b1;
    m_req[0][0] = 1'b0;
    at_neg(t + 5);
    check("midrst_outputs_dut0", all_out(0), '0);
    check("midrst_outputs_dut1", all_out(1), '0);
    goto(t + 6);
    rst = 1'b0;
    for (int d = 0; d < 2; d++)
      for (int m = 0; m < 2; m++)
        exp_dout[d][m] = '0;
    goto(t + 8);
    t = cyc;
    m_req[0][0] = 1'b1;
    exp_dout[0][0] = 48'h1234_5678_9ABC;
    expect_ack(0, 0, 1'b0, t + 8);
    goto(t + 9);
    m_req[0][0] = 1'b0;

    goto(cyc + 5);
    check("missing_acks", 192'(sb.size()), 192'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
